// File: rtl/fecha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fecha_pkg
// Description : Shared constants for the date-edit front end: cursor field
//               codes, FSM state encoding and cursor stepping helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fecha_pkg;

  // Field selected by the cursor (pos_x); value 3 is never produced.
  localparam logic [1:0] POS_DIA  = 2'd0;
  localparam logic [1:0] POS_MES  = 2'd1;
  localparam logic [1:0] POS_ANIO = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_SAVE = 2'd2
  } estado_t;

  // Cursor step to the right: day -> month -> year -> day.
  function automatic logic [1:0] pos_siguiente(input logic [1:0] pos);
    logic [1:0] res;
    case (pos)
      POS_DIA: res = POS_MES;
      POS_MES: res = POS_ANIO;
      default: res = POS_DIA;
    endcase
    return res;
  endfunction

  // Cursor step to the left: day -> year -> month -> day.
  function automatic logic [1:0] pos_anterior(input logic [1:0] pos);
    logic [1:0] res;
    case (pos)
      POS_DIA:  res = POS_ANIO;
      POS_ANIO: res = POS_MES;
      default:  res = POS_DIA;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/antirrebote.sv
`default_nettype none
// ============================================================================
// Module      : antirrebote
// Description : Pushbutton conditioner: 2-FF synchronizer, debounce filter
//               and a one-cycle pulse on each accepted 0->1 transition.
// Ports       : clk    in  system clock
//               reset  in  asynchronous active-high reset
//               boton  in  raw asynchronous button, high = pressed
//               nivel  out debounced level
//               pulso  out one-cycle pulse, coincident with nivel's rise
// Revision    : 1.0 - initial release
// ============================================================================
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic nivel,
  output logic pulso
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cuenta <= '0;
      nivel  <= 1'b0;
      pulso  <= 1'b0;
    end else begin
      sync_1 <= boton;
      sync_2 <= sync_1;
      pulso  <= 1'b0;
      // The count only advances while the synchronized input disagrees with
      // the accepted level; any agreement (a bounce) restarts it.
      if (sync_2 != nivel) begin
        if (cuenta == DB_LAST) begin
          nivel  <= sync_2;
          pulso  <= sync_2;
          cuenta <= '0;
        end else begin
          cuenta <= cuenta + 1'b1;
        end
      end else begin
        cuenta <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_edicion_fecha.sv
`default_nettype none
// ============================================================================
// Module      : control_edicion_fecha
// Description : Date-edit front end. Conditions the five board pushbuttons
//               and runs the edit-mode FSM driving contador_fecha (cambiar_fecha,
//               boton_u, boton_d, pos_x), the save strobe for the RTC writer
//               and the cursor blink enable.
// Ports       : clk, reset (async, active high)
//               btn_up/down/left/right/edit  raw pushbuttons
//               cambiar_fecha  high while editing
//               boton_u/boton_d gated debounced up/down levels
//               pos_x          field select (0 day, 1 month, 2 year)
//               guardar_fecha  one-cycle store strobe on leaving edit mode
//               parpadeo       blink enable for the selected field
// Revision    : 1.0 - initial release
// ============================================================================
module control_edicion_fecha
  import fecha_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int INACT_CYCLES    = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_edit,
  output logic       cambiar_fecha,
  output logic       boton_u,
  output logic       boton_d,
  output logic [1:0] pos_x,
  output logic       guardar_fecha,
  output logic       parpadeo
);

  localparam int NUM_BTN = 5;
  localparam int B_EDIT  = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;

  localparam int            BW         = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam int            IW         = $clog2(INACT_CYCLES + 1);
  localparam logic [IW-1:0] INACT_LAST = IW'(INACT_CYCLES - 1);

  logic [NUM_BTN-1:0] crudo;
  logic [NUM_BTN-1:0] nivel;
  logic [NUM_BTN-1:0] subida;

  assign crudo[B_EDIT]  = btn_edit;
  assign crudo[B_UP]    = btn_up;
  assign crudo[B_DOWN]  = btn_down;
  assign crudo[B_LEFT]  = btn_left;
  assign crudo[B_RIGHT] = btn_right;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_antirrebote
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
      .clk  (clk),
      .reset(reset),
      .boton(crudo[i]),
      .nivel(nivel[i]),
      .pulso(subida[i])
    );
  end

  // Only the up/down levels are consumed; the others act through their pulses.
  logic unused_niveles;
  assign unused_niveles = ^{nivel[B_EDIT], nivel[B_LEFT], nivel[B_RIGHT]};

  estado_t       state;
  estado_t       next_state;
  logic          arm_u;
  logic          arm_d;
  logic [IW-1:0] inact_cnt;
  logic [BW-1:0] blink_cnt;
  logic          en_edicion;
  logic          entrando;
  logic          mover;
  logic          inact_fin;

  // --------------------------------------------------------------------------
  // FSM: state register and next-state / output decode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  assign inact_fin = (inact_cnt == INACT_LAST);

  always_comb begin
    next_state    = state;
    cambiar_fecha = 1'b0;
    guardar_fecha = 1'b0;
    case (state)
      ST_IDLE: begin
        if (subida[B_EDIT]) next_state = ST_EDIT;
      end
      ST_EDIT: begin
        cambiar_fecha = 1'b1;
        if (subida[B_EDIT] || inact_fin) next_state = ST_SAVE;
      end
      ST_SAVE: begin
        // Counter already left edit mode but still holds the edited date.
        guardar_fecha = 1'b1;
        next_state    = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign en_edicion = (state == ST_EDIT);
  assign entrando   = (state == ST_IDLE) && (next_state == ST_EDIT);
  // Edit wins over a simultaneous cursor press; left+right together cancel.
  assign mover      = en_edicion && !subida[B_EDIT] && (subida[B_LEFT] ^ subida[B_RIGHT]);

  // --------------------------------------------------------------------------
  // Cursor
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x <= POS_DIA;
    end else if (entrando) begin
      pos_x <= POS_DIA;
    end else if (mover) begin
      pos_x <= subida[B_RIGHT] ? pos_siguiente(pos_x) : pos_anterior(pos_x);
    end
  end

  // --------------------------------------------------------------------------
  // Up/down gating: a button already held when editing starts must be seen
  // released before it may reach the counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_u <= 1'b0;
      arm_d <= 1'b0;
    end else if (entrando) begin
      arm_u <= 1'b0;
      arm_d <= 1'b0;
    end else if (en_edicion) begin
      if (!nivel[B_UP])   arm_u <= 1'b1;
      if (!nivel[B_DOWN]) arm_d <= 1'b1;
    end
  end

  assign boton_u = nivel[B_UP]   && en_edicion && arm_u;
  assign boton_d = nivel[B_DOWN] && en_edicion && arm_d;

  // --------------------------------------------------------------------------
  // Inactivity timeout: saturating, restarted by any button press.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inact_cnt <= '0;
    end else if (!en_edicion || (|subida)) begin
      inact_cnt <= '0;
    end else if (!inact_fin) begin
      inact_cnt <= inact_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Cursor blink. Decoded from next_state so parpadeo tracks cambiar_fecha
  // cycle for cycle; it restarts visible on entry and after every move.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parpadeo  <= 1'b0;
      blink_cnt <= '0;
    end else if (next_state != ST_EDIT) begin
      parpadeo  <= 1'b0;
      blink_cnt <= '0;
    end else if (entrando || mover) begin
      parpadeo  <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      parpadeo  <= ~parpadeo;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_edicion_fecha.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_edicion_fecha
// Description : Directed self-checking bench for control_edicion_fecha with
//               DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, INACT_CYCLES=50.
//               Inputs change on the falling edge; outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_edicion_fecha;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_right = 1'b0, btn_edit = 1'b0;
  logic       cambiar_fecha, boton_u, boton_d, guardar_fecha, parpadeo;
  logic [1:0] pos_x;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [4:0] M_E = 5'b10000;
  localparam logic [4:0] M_U = 5'b01000;
  localparam logic [4:0] M_D = 5'b00100;
  localparam logic [4:0] M_L = 5'b00010;
  localparam logic [4:0] M_R = 5'b00001;

  control_edicion_fecha #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES   (8),
    .INACT_CYCLES   (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_edit     (btn_edit),
    .cambiar_fecha(cambiar_fecha),
    .boton_u      (boton_u),
    .boton_d      (boton_d),
    .pos_x        (pos_x),
    .guardar_fecha(guardar_fecha),
    .parpadeo     (parpadeo)
  );

  always #5 clk = ~clk;

  task automatic set_btns(input logic [4:0] m);
    {btn_edit, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A press applied on a falling edge takes effect on the 7th rising edge
  // (2 sync + 4 debounce + 1), so it is visible on the 7th falling edge.

  task automatic test_reset;
    wait_neg(2);
    n_cmp++;
    if ({cambiar_fecha, boton_u, boton_d, pos_x, guardar_fecha, parpadeo} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {cambiar_fecha, boton_u, boton_d, pos_x, guardar_fecha, parpadeo});
    end
    reset = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_edit_toggle;
    set_btns(M_E);
    wait_neg(6);
    n_cmp++;
    if (cambiar_fecha !== 1'b0) begin n_fail++; $display("FAIL t1_early: cambiar_fecha=%b required 0", cambiar_fecha); end
    wait_neg(1);
    n_cmp++;
    if ({cambiar_fecha, pos_x, parpadeo} !== 4'b1001) begin
      n_fail++; $display("FAIL t1_entry: {cambiar,pos_x,parpadeo}=%b required 1001", {cambiar_fecha, pos_x, parpadeo});
    end
    wait_neg(3);
    set_btns(5'b0);
    wait_neg(8);
    set_btns(M_E);
    wait_neg(6);
    n_cmp++;
    if ({cambiar_fecha, guardar_fecha} !== 2'b10) begin
      n_fail++; $display("FAIL t1_pre_save: {cambiar,guardar}=%b required 10", {cambiar_fecha, guardar_fecha});
    end
    wait_neg(1);
    n_cmp++;
    if ({cambiar_fecha, guardar_fecha} !== 2'b01) begin
      n_fail++; $display("FAIL t1_save: {cambiar,guardar}=%b required 01", {cambiar_fecha, guardar_fecha});
    end
    wait_neg(1);
    n_cmp++;
    if ({cambiar_fecha, guardar_fecha, parpadeo} !== 3'b000) begin
      n_fail++; $display("FAIL t1_idle: {cambiar,guardar,parpadeo}=%b required 000", {cambiar_fecha, guardar_fecha, parpadeo});
    end
    set_btns(5'b0);
    wait_neg(8);
  endtask

  task automatic test_blink;
    set_btns(M_E);
    wait_neg(7);
    set_btns(5'b0);
    for (int j = 0; j <= 16; j++) begin
      n_cmp++;
      if (parpadeo !== ((j < 8) || (j == 16))) begin
        n_fail++; $display("FAIL blink_%0d: parpadeo=%b required %b", j, parpadeo, (j < 8) || (j == 16));
      end
      wait_neg(1);
    end
    set_btns(M_E);
    wait_neg(6);
    set_btns(5'b0);
    wait_neg(9);
  endtask

  task automatic test_bounce;
    int highs, rises;
    logic prev;
    set_btns(M_E);
    wait_neg(7);
    set_btns(5'b0);
    wait_neg(8);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2 == 0);
      wait_neg(1);
      if (boton_u) highs++;
    end
    n_cmp++;
    if (highs != 0) begin n_fail++; $display("FAIL bounce_glitch: boton_u high %0d cycles required 0", highs); end
    btn_up = 1'b1;
    prev = 1'b0; rises = 0;
    for (int i = 0; i < 20; i++) begin
      wait_neg(1);
      if (i == 9) btn_up = 1'b0;
      if (i == 4 || i == 5) begin
        n_cmp++;
        if (boton_u !== (i == 5)) begin n_fail++; $display("FAIL bounce_edge_%0d: boton_u=%b required %b", i, boton_u, i == 5); end
      end
      if (boton_u && !prev) rises++;
      if (boton_u) highs++;
      prev = boton_u;
    end
    n_cmp++;
    if (rises != 1 || highs != 10) begin
      n_fail++; $display("FAIL bounce_pulse: rises=%0d highs=%0d required 1 and 10", rises, highs);
    end
    set_btns(M_E);
    wait_neg(7);
    n_cmp++;
    if (guardar_fecha !== 1'b1) begin n_fail++; $display("FAIL bounce_exit: guardar_fecha=%b required 1", guardar_fecha); end
    set_btns(5'b0);
    wait_neg(8);
  endtask

  task automatic test_cursor;
    logic [1:0] exp_r [4];
    exp_r[0] = 2'd1; exp_r[1] = 2'd2; exp_r[2] = 2'd0; exp_r[3] = 2'd1;
    set_btns(M_E);
    wait_neg(7);
    n_cmp++;
    if (pos_x !== 2'd0) begin n_fail++; $display("FAIL cursor_entry: pos_x=%0d required 0", pos_x); end
    set_btns(5'b0);
    wait_neg(8);
    for (int k = 0; k < 4; k++) begin
      set_btns(M_R);
      wait_neg(7);
      n_cmp++;
      if (pos_x !== exp_r[k]) begin n_fail++; $display("FAIL cursor_right_%0d: pos_x=%0d required %0d", k, pos_x, exp_r[k]); end
      set_btns(5'b0);
      wait_neg(8);
    end
    set_btns(M_L);
    wait_neg(7);
    n_cmp++;
    if (pos_x !== 2'd0) begin n_fail++; $display("FAIL cursor_left: pos_x=%0d required 0", pos_x); end
    set_btns(5'b0);
    wait_neg(8);
    set_btns(M_L | M_R);
    wait_neg(7);
    n_cmp++;
    if (pos_x !== 2'd0) begin n_fail++; $display("FAIL cursor_both: pos_x=%0d required 0", pos_x); end
    set_btns(5'b0);
    wait_neg(8);
    set_btns(M_E | M_R);
    wait_neg(7);
    n_cmp++;
    if ({guardar_fecha, pos_x} !== 3'b100) begin
      n_fail++; $display("FAIL cursor_edit_wins: {guardar,pos_x}=%b required 100", {guardar_fecha, pos_x});
    end
    set_btns(5'b0);
    wait_neg(8);
  endtask

  task automatic test_arm;
    int highs;
    set_btns(M_U);
    wait_neg(8);
    set_btns(M_U | M_E);
    wait_neg(7);
    n_cmp++;
    if ({cambiar_fecha, boton_u} !== 2'b10) begin
      n_fail++; $display("FAIL arm_entry: {cambiar,boton_u}=%b required 10", {cambiar_fecha, boton_u});
    end
    set_btns(M_U);
    highs = 0;
    for (int i = 0; i < 8; i++) begin wait_neg(1); if (boton_u) highs++; end
    set_btns(5'b0);
    for (int i = 0; i < 10; i++) begin wait_neg(1); if (boton_u) highs++; end
    n_cmp++;
    if (highs != 0) begin n_fail++; $display("FAIL arm_held: boton_u high %0d cycles required 0", highs); end
    set_btns(M_U);
    wait_neg(5);
    n_cmp++;
    if (boton_u !== 1'b0) begin n_fail++; $display("FAIL arm_pre: boton_u=%b required 0", boton_u); end
    wait_neg(1);
    n_cmp++;
    if (boton_u !== 1'b1) begin n_fail++; $display("FAIL arm_second_press: boton_u=%b required 1", boton_u); end
    wait_neg(4);
    set_btns(M_D);
    wait_neg(6);
    n_cmp++;
    if ({boton_u, boton_d} !== 2'b01) begin
      n_fail++; $display("FAIL arm_down: {boton_u,boton_d}=%b required 01", {boton_u, boton_d});
    end
    wait_neg(2);
    set_btns(5'b0);
    wait_neg(8);
    set_btns(M_E);
    wait_neg(7);
    set_btns(5'b0);
    wait_neg(8);
  endtask

  task automatic test_inactivity;
    set_btns(M_E);
    wait_neg(7);
    set_btns(5'b0);
    for (int j = 1; j <= 51; j++) begin
      wait_neg(1);
      n_cmp++;
      if ({cambiar_fecha, guardar_fecha} !== {(j < 50), (j == 50)}) begin
        n_fail++; $display("FAIL inact_%0d: {cambiar,guardar}=%b required %b%b", j, {cambiar_fecha, guardar_fecha}, j < 50, j == 50);
      end
    end
    wait_neg(5);
    set_btns(M_E);
    wait_neg(7);
    set_btns(5'b0);
    for (int j = 1; j <= 98; j++) begin
      wait_neg(1);
      if (j == 40) set_btns(M_R);
      if (j == 48) set_btns(5'b0);
      n_cmp++;
      if ({cambiar_fecha, guardar_fecha} !== {(j < 97), (j == 97)}) begin
        n_fail++; $display("FAIL inact_delay_%0d: {cambiar,guardar}=%b required %b%b", j, {cambiar_fecha, guardar_fecha}, j < 97, j == 97);
      end
      if (j == 60) begin
        n_cmp++;
        if (pos_x !== 2'd1) begin n_fail++; $display("FAIL inact_move: pos_x=%0d required 1", pos_x); end
      end
    end
    wait_neg(5);
  endtask

  task automatic test_reset_mid_edit;
    int bad;
    set_btns(M_E);
    wait_neg(7);
    set_btns(5'b0);
    wait_neg(8);
    set_btns(M_R);
    wait_neg(7);
    set_btns(5'b0);
    wait_neg(8);
    set_btns(M_U);
    wait_neg(7);
    n_cmp++;
    if ({cambiar_fecha, boton_u, pos_x} !== 4'b1101) begin
      n_fail++; $display("FAIL rst_pre: {cambiar,boton_u,pos_x}=%b required 1101", {cambiar_fecha, boton_u, pos_x});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({cambiar_fecha, boton_u, boton_d, pos_x, guardar_fecha, parpadeo} !== 7'b0) begin
      n_fail++; $display("FAIL rst_async: outputs=%b required 0000000",
                         {cambiar_fecha, boton_u, boton_d, pos_x, guardar_fecha, parpadeo});
    end
    wait_neg(2);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      wait_neg(1);
      if (guardar_fecha || cambiar_fecha || boton_u || parpadeo) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_after: %0d cycles with outputs active, required 0", bad); end
    set_btns(5'b0);
    wait_neg(8);
  endtask

  initial begin
    test_reset();
    test_edit_toggle();
    test_blink();
    test_bounce();
    test_cursor();
    test_arm();
    test_inactivity();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
